// File: rtl/match_ctrl.sv
// Game-flow sequencer for the volleyball datapath: gates the physics step enable,
// drives the physics reset and sequences serve, point, pause and match-over phases.
module match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       point_pulse,
  input  logic [3:0] p1_score,
  input  logic [3:0] p2_score,
  output logic       phys_step,
  output logic       phys_rst_n,
  output logic [2:0] state_o,
  output logic [7:0] countdown,
  output logic       serve_side,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    SERVE = 3'd2,
    PLAY  = 3'd3,
    POINT = 3'd4,
    PAUSE = 3'd5,
    OVER  = 3'd6
  } state_t;

  localparam logic [3:0] WIN_PTS  = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_CD = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_CD = 8'(POINT_FRAMES);

  state_t     state, state_n;
  logic [7:0] cd_n;
  logic       side_n;
  logic [1:0] win_n;
  logic [3:0] p1_shadow, p2_shadow, p1_shadow_n, p2_shadow_n;
  logic       p1_scored;
  logic [3:0] scorer_pts;

  assign p1_scored  = (p1_score != p1_shadow);
  assign scorer_pts = p1_scored ? p1_score : p2_score;

  always_comb begin
    state_n     = state;
    cd_n        = countdown;
    side_n      = serve_side;
    win_n       = winner;
    p1_shadow_n = p1_shadow;
    p2_shadow_n = p2_shadow;
    // A start request restarts the match from anywhere except mid-INIT; the
    // match state is cleared on the way in so INIT already shows a fresh match.
    if (start_btn && state != INIT) begin
      state_n     = INIT;
      cd_n        = 8'd0;
      side_n      = 1'b0;
      win_n       = 2'b00;
      p1_shadow_n = 4'd0;
      p2_shadow_n = 4'd0;
    end else begin
      case (state)
        IDLE: cd_n = 8'd0;
        INIT: begin
          state_n = SERVE;
          cd_n    = SERVE_CD;
        end
        SERVE, POINT: begin
          if (frame_tick) begin
            if (countdown <= 8'd1) begin
              state_n = (state == SERVE) ? PLAY : SERVE;
              cd_n    = (state == SERVE) ? 8'd0 : SERVE_CD;
            end else begin
              cd_n = countdown - 8'd1;
            end
          end
        end
        PLAY: begin
          if (point_pulse) begin
            side_n      = ~p1_scored;
            p1_shadow_n = p1_score;
            p2_shadow_n = p2_score;
            if (scorer_pts >= WIN_PTS) begin
              state_n = OVER;
              cd_n    = 8'd0;
              win_n   = p1_scored ? 2'b01 : 2'b10;
            end else begin
              state_n = POINT;
              cd_n    = POINT_CD;
            end
          end else if (pause_btn) begin
            state_n = PAUSE;
          end
        end
        PAUSE: begin
          if (pause_btn) state_n = PLAY;
        end
        OVER: ;
        default: begin
          state_n = IDLE;
          cd_n    = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      countdown  <= 8'd0;
      serve_side <= 1'b0;
      winner     <= 2'b00;
      p1_shadow  <= 4'd0;
      p2_shadow  <= 4'd0;
      phys_rst_n <= 1'b0;
    end else begin
      state      <= state_n;
      countdown  <= cd_n;
      serve_side <= side_n;
      winner     <= win_n;
      p1_shadow  <= p1_shadow_n;
      p2_shadow  <= p2_shadow_n;
      phys_rst_n <= !(state_n == IDLE || state_n == INIT);
    end
  end

  assign phys_step = frame_tick && (state == PLAY);
  assign state_o   = state;

endmodule
